// File: rtl/branch_redirect_ctrl.sv
// Branch resolution controller for the execute stage.
// Latches one branch, evaluates it in a dedicated cycle, and on a mispredict
// hands a corrected PC to fetch (valid/ready-style handshake), then holds a
// fixed-length flush of the younger IF/ID instructions. Execute is stalled
// whenever the controller is not idle. Taken and mispredict counts are kept in
// saturating statistics counters.
//
// Handshakes:
//   br_valid/br_ready: a branch transfers on a rising edge where both are high.
//     br_ready is high exactly in IDLE, so br_valid elsewhere is ignored.
//   redirect_valid/redirect_ack: the redirect transfers on a rising edge where
//     both are high. redirect_valid and redirect_pc stay stable until then.
//     redirect_ack without redirect_valid has no effect.
module branch_redirect_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_op,
    input  logic             br_jump,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    input  logic [XLEN-1:0]  br_pc,
    input  logic [XLEN-1:0]  br_imm,
    input  logic             br_pred_taken,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    input  logic             redirect_ack,
    output logic             flush,
    output logic             stall,
    output logic             misalign_err,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [1:0]       dbg_state
);

    // Flush down-counter sized to hold FLUSH_CYCLES itself.
    localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(1);

    // Branch condition encodings on br_op.
    localparam logic [2:0] OP_BEQ  = 3'b000;
    localparam logic [2:0] OP_BNE  = 3'b001;
    localparam logic [2:0] OP_BLT  = 3'b100;
    localparam logic [2:0] OP_BGE  = 3'b101;
    localparam logic [2:0] OP_BLTU = 3'b110;
    localparam logic [2:0] OP_BGEU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EVAL     = 2'd1,
        S_REDIRECT = 2'd2,
        S_FLUSH    = 2'd3
    } state_t;

    state_t state_q;

    // Branch captured at accept; execute may change its inputs afterwards.
    logic [2:0]      op_q;
    logic            jump_q;
    logic            pred_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_q;

    // Registered outputs.
    logic             br_ready_q;
    logic             stall_q;
    logic             redirect_valid_q;
    logic [XLEN-1:0]  redirect_pc_q;
    logic             flush_q;
    logic             misalign_q;
    logic [CNT_W-1:0] taken_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_q;
    logic [FC_W-1:0]  flush_cnt_q;

    // Combinational evaluation of the latched branch, consumed only in EVAL.
    logic             cond;
    logic             taken;
    logic             target_misaligned;
    logic             mispredict;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  seq_pc;
    logic [XLEN-1:0]  redirect_pc_d;
    logic [CNT_W-1:0] taken_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_d;

    // Condition decode, outcome, target arithmetic and saturating increments.
    always_comb begin
        cond = 1'b0;
        case (op_q)
            OP_BEQ:  cond = (a_q == b_q);
            OP_BNE:  cond = (a_q != b_q);
            OP_BLT:  cond = ($signed(a_q) <  $signed(b_q));
            OP_BGE:  cond = ($signed(a_q) >= $signed(b_q));
            OP_BLTU: cond = (a_q <  b_q);
            OP_BGEU: cond = (a_q >= b_q);
            default: cond = 1'b0;   // 010/011 reserved: never taken
        endcase

        taken             = jump_q | cond;
        target            = pc_q + imm_q;          // wraps modulo 2^XLEN
        seq_pc            = pc_q + XLEN'(4);       // wraps modulo 2^XLEN
        target_misaligned = (target[1:0] != 2'b00);
        mispredict        = (taken != pred_q);
        redirect_pc_d     = taken ? target : seq_pc;

        taken_cnt_d   = (taken_cnt_q == '1)   ? taken_cnt_q   : taken_cnt_q + CNT_W'(1);
        mispred_cnt_d = (mispred_cnt_q == '1) ? mispred_cnt_q : mispred_cnt_q + CNT_W'(1);
    end

    // Controller FSM: state, latched branch, all registered outputs and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            op_q             <= '0;
            jump_q           <= 1'b0;
            pred_q           <= 1'b0;
            a_q              <= '0;
            b_q              <= '0;
            pc_q             <= '0;
            imm_q            <= '0;
            br_ready_q       <= 1'b1;
            stall_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            misalign_q       <= 1'b0;
            taken_cnt_q      <= '0;
            mispred_cnt_q    <= '0;
            flush_cnt_q      <= '0;
        end else begin
            // misalign_err is a single-cycle pulse unless EVAL re-asserts it.
            misalign_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (br_valid && br_ready_q) begin
                        op_q       <= br_op;
                        jump_q     <= br_jump;
                        pred_q     <= br_pred_taken;
                        a_q        <= rs1_val;
                        b_q        <= rs2_val;
                        pc_q       <= br_pc;
                        imm_q      <= br_imm;
                        state_q    <= S_EVAL;
                        br_ready_q <= 1'b0;
                        stall_q    <= 1'b1;
                    end
                end

                S_EVAL: begin
                    if (taken && target_misaligned) begin
                        // Faulting target: report it, but neither redirect nor count.
                        misalign_q <= 1'b1;
                        state_q    <= S_IDLE;
                        br_ready_q <= 1'b1;
                        stall_q    <= 1'b0;
                    end else begin
                        if (taken) begin
                            taken_cnt_q <= taken_cnt_d;
                        end
                        if (mispredict) begin
                            redirect_pc_q    <= redirect_pc_d;
                            redirect_valid_q <= 1'b1;
                            flush_q          <= 1'b1;
                            state_q          <= S_REDIRECT;
                        end else begin
                            state_q    <= S_IDLE;
                            br_ready_q <= 1'b1;
                            stall_q    <= 1'b0;
                        end
                    end
                end

                S_REDIRECT: begin
                    // Hold the request stable until fetch takes it.
                    if (redirect_ack) begin
                        redirect_valid_q <= 1'b0;
                        mispred_cnt_q    <= mispred_cnt_d;
                        flush_cnt_q      <= FC_LOAD;
                        state_q          <= S_FLUSH;
                    end
                end

                S_FLUSH: begin
                    // flush stays high for FLUSH_CYCLES cycles after the ack edge.
                    flush_cnt_q <= flush_cnt_q - FC_W'(1);
                    if (flush_cnt_q <= FC_LAST) begin
                        flush_cnt_q <= '0;
                        flush_q     <= 1'b0;
                        state_q     <= S_IDLE;
                        br_ready_q  <= 1'b1;
                        stall_q     <= 1'b0;
                    end
                end

                default: begin
                    state_q          <= S_IDLE;
                    br_ready_q       <= 1'b1;
                    stall_q          <= 1'b0;
                    redirect_valid_q <= 1'b0;
                    flush_q          <= 1'b0;
                end
            endcase
        end
    end

    assign br_ready       = br_ready_q;
    assign stall          = stall_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign misalign_err   = misalign_q;
    assign taken_cnt      = taken_cnt_q;
    assign mispred_cnt    = mispred_cnt_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed branch scenarios, handshake hold,
// asynchronous reset mid-redirect, randomized traffic and counter saturation.
module tb_branch_redirect_ctrl;

  localparam int XLEN         = 32;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 4;

  localparam logic [1:0] K_NONE     = 2'd0;
  localparam logic [1:0] K_MISALIGN = 2'd1;
  localparam logic [1:0] K_REDIRECT = 2'd2;

  logic             clk;
  logic             rst;
  logic             br_valid;
  logic             br_ready;
  logic [2:0]       br_op;
  logic             br_jump;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  rs2_val;
  logic [XLEN-1:0]  br_pc;
  logic [XLEN-1:0]  br_imm;
  logic             br_pred_taken;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             redirect_ack;
  logic             flush;
  logic             stall;
  logic             misalign_err;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] mispred_cnt;
  logic [1:0]       dbg_state;

  // Scoreboard: {kind, redirect_pc} per accepted branch.
  logic [XLEN+1:0]  exp_q[$];
  logic [CNT_W-1:0] exp_taken;
  logic [CNT_W-1:0] exp_mispred;

  int n_tests;
  int n_fail;

  branch_redirect_ctrl #(
    .XLEN(XLEN),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .br_valid(br_valid),
    .br_ready(br_ready),
    .br_op(br_op),
    .br_jump(br_jump),
    .rs1_val(rs1_val),
    .rs2_val(rs2_val),
    .br_pc(br_pc),
    .br_imm(br_imm),
    .br_pred_taken(br_pred_taken),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .redirect_ack(redirect_ack),
    .flush(flush),
    .stall(stall),
    .misalign_err(misalign_err),
    .taken_cnt(taken_cnt),
    .mispred_cnt(mispred_cnt),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + CNT_W'(1);
  endfunction

  // Reference model of one branch outcome; cnt_taken reports whether taken_cnt moves.
  function automatic logic [XLEN+1:0] model_branch(
    input  logic [2:0]      op,
    input  logic            jump,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            pred,
    output logic            cnt_taken
  );
    logic            c;
    logic            tk;
    logic            slt;
    logic            ult;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] seq;
    ult = (a < b);
    // Signed less-than from sign bits: differing signs decide, else unsigned order.
    slt = (a[XLEN-1] != b[XLEN-1]) ? a[XLEN-1] : ult;
    case (op)
      3'b000:  c = (a == b);
      3'b001:  c = (a != b);
      3'b100:  c = slt;
      3'b101:  c = !slt;
      3'b110:  c = ult;
      3'b111:  c = !ult;
      default: c = 1'b0;
    endcase
    tk  = jump | c;
    tgt = pc + imm;
    seq = pc + XLEN'(4);
    cnt_taken = 1'b0;
    if (tk && (tgt[1:0] != 2'b00)) return {K_MISALIGN, {XLEN{1'b0}}};
    cnt_taken = tk;
    if (tk != pred) return {K_REDIRECT, (tk ? tgt : seq)};
    return {K_NONE, {XLEN{1'b0}}};
  endfunction

  // Driver: issue one branch and follow it through to idle (or reset at rst_cycle).
  task automatic run_branch(
    input string           tag,
    input logic [2:0]      op,
    input logic            jump,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b,
    input logic [XLEN-1:0] pc,
    input logic [XLEN-1:0] imm,
    input logic            pred,
    input int              ack_delay,
    input int              rst_cycle
  );
    logic [XLEN+1:0] e;
    logic            cnt_tk;
    logic [1:0]      kind;
    e = model_branch(op, jump, a, b, pc, imm, pred, cnt_tk);
    exp_q.push_back(e);
    if (cnt_tk) exp_taken = sat_inc(exp_taken);

    @(negedge clk);
    br_op = op; br_jump = jump; rs1_val = a; rs2_val = b;
    br_pc = pc; br_imm = imm; br_pred_taken = pred; br_valid = 1'b1;
    n_tests++;
    if (br_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept_ready: br_ready=%b expected 1", tag, br_ready);
    end

    // EVAL cycle: scramble inputs to show the branch was latched.
    @(negedge clk);
    rs1_val = $urandom; rs2_val = $urandom; br_pc = $urandom; br_imm = $urandom;
    br_pred_taken = ~pred; br_op = op ^ 3'b001;
    n_tests++;
    if ({br_ready, stall, redirect_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL %s eval_cycle: {ready,stall,rv}=%b expected 010", tag, {br_ready, stall, redirect_valid});
    end

    // Outcome cycle (T+2).
    @(negedge clk);
    e = exp_q.pop_front();
    kind = e[XLEN+1:XLEN];
    if (kind != K_REDIRECT) br_valid = 1'b0;

    if (kind == K_REDIRECT) begin
      n_tests++;
      if ({redirect_valid, flush, stall, br_ready, misalign_err} !== 5'b11100 ||
          redirect_pc !== e[XLEN-1:0]) begin
        n_fail++;
        $display("FAIL %s redirect: {rv,fl,st,rdy,mis}=%b pc=%h expected 11100 pc=%h",
                 tag, {redirect_valid, flush, stall, br_ready, misalign_err}, redirect_pc, e[XLEN-1:0]);
      end
      for (int i = 0; i < ack_delay; i++) begin
        @(negedge clk);
        if (i == rst_cycle) begin
          #1 rst = 1'b1;
          #1;
          exp_taken = '0;
          exp_mispred = '0;
          n_tests++;
          if ({br_ready, stall, redirect_valid, flush, misalign_err} !== 5'b10000 ||
              redirect_pc !== '0 || taken_cnt !== '0 || mispred_cnt !== '0) begin
            n_fail++;
            $display("FAIL %s async_reset: {rdy,st,rv,fl,mis}=%b pc=%h tc=%h mc=%h expected 10000 all zero",
                     tag, {br_ready, stall, redirect_valid, flush, misalign_err}, redirect_pc, taken_cnt, mispred_cnt);
          end
          br_valid = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          @(negedge clk);
          n_tests++;
          if (br_ready !== 1'b1 || dbg_state !== 2'd0 || redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s post_reset_idle: rdy=%b state=%0d rv=%b expected 1 0 0",
                     tag, br_ready, dbg_state, redirect_valid);
          end
          return;
        end
        n_tests++;
        if ({redirect_valid, flush, stall, br_ready} !== 4'b1110 || redirect_pc !== e[XLEN-1:0]) begin
          n_fail++;
          $display("FAIL %s redirect_hold[%0d]: {rv,fl,st,rdy}=%b pc=%h expected 1110 pc=%h",
                   tag, i, {redirect_valid, flush, stall, br_ready}, redirect_pc, e[XLEN-1:0]);
        end
      end
      redirect_ack = 1'b1;
      br_valid = 1'b0;
      @(negedge clk);
      redirect_ack = 1'b0;
      exp_mispred = sat_inc(exp_mispred);
      n_tests++;
      if ({redirect_valid, flush, stall} !== 3'b011) begin
        n_fail++;
        $display("FAIL %s after_ack: {rv,fl,st}=%b expected 011", tag, {redirect_valid, flush, stall});
      end
      for (int k = 1; k < FLUSH_CYCLES; k++) begin
        @(negedge clk);
        n_tests++;
        if ({flush, stall, br_ready} !== 3'b110) begin
          n_fail++;
          $display("FAIL %s flush_hold[%0d]: {fl,st,rdy}=%b expected 110", tag, k, {flush, stall, br_ready});
        end
      end
      @(negedge clk);
      n_tests++;
      if ({flush, stall, br_ready} !== 3'b001) begin
        n_fail++;
        $display("FAIL %s flush_end: {fl,st,rdy}=%b expected 001", tag, {flush, stall, br_ready});
      end
    end else if (kind == K_MISALIGN) begin
      n_tests++;
      if ({misalign_err, redirect_valid, br_ready, stall} !== 4'b1010) begin
        n_fail++;
        $display("FAIL %s misalign: {mis,rv,rdy,st}=%b expected 1010", tag, {misalign_err, redirect_valid, br_ready, stall});
      end
      @(negedge clk);
      n_tests++;
      if (misalign_err !== 1'b0) begin
        n_fail++;
        $display("FAIL %s misalign_pulse: misalign_err=%b expected 0", tag, misalign_err);
      end
    end else begin
      n_tests++;
      if ({misalign_err, redirect_valid, br_ready, stall} !== 4'b0010) begin
        n_fail++;
        $display("FAIL %s no_redirect: {mis,rv,rdy,st}=%b expected 0010", tag, {misalign_err, redirect_valid, br_ready, stall});
      end
    end

    n_tests++;
    if (taken_cnt !== exp_taken || mispred_cnt !== exp_mispred) begin
      n_fail++;
      $display("FAIL %s counters: taken=%0d mispred=%0d expected %0d %0d",
               tag, taken_cnt, mispred_cnt, exp_taken, exp_mispred);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; br_valid = 1'b0; br_op = '0; br_jump = 1'b0; rs1_val = '0; rs2_val = '0;
    br_pc = '0; br_imm = '0; br_pred_taken = 1'b0; redirect_ack = 1'b0;
    exp_taken = '0; exp_mispred = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({br_ready, stall, redirect_valid, flush, misalign_err} !== 5'b10000 ||
        redirect_pc !== '0 || taken_cnt !== '0 || mispred_cnt !== '0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_values: {rdy,st,rv,fl,mis}=%b pc=%h tc=%h mc=%h state=%0d expected 10000 zeros",
               {br_ready, stall, redirect_valid, flush, misalign_err}, redirect_pc, taken_cnt, mispred_cnt, dbg_state);
    end
    rst = 1'b0;
    // Stray ack while idle must do nothing.
    redirect_ack = 1'b1;
    repeat (3) @(negedge clk);
    redirect_ack = 1'b0;
    n_tests++;
    if (redirect_valid !== 1'b0 || mispred_cnt !== '0 || br_ready !== 1'b1 || flush !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ack_ignored: rv=%b mc=%h rdy=%b fl=%b expected 0 0 1 0",
               redirect_valid, mispred_cnt, br_ready, flush);
    end
  endtask

  task automatic test_beq_redirect();
    run_branch("beq_redirect", 3'b000, 1'b0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 0, -1);
  endtask

  task automatic test_signed_unsigned();
    run_branch("blt_signed", 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b1, 0, -1);
    run_branch("bltu_unsigned", 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b1, 1, -1);
    run_branch("bne_taken", 3'b001, 1'b0, 32'd3, 32'd4, 32'h400, 32'hFFFF_FFF0, 1'b0, 2, -1);
  endtask

  task automatic test_ge_reserved();
    run_branch("bge_equal", 3'b101, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h500, 32'h8, 1'b0, 0, -1);
    run_branch("bgeu_equal", 3'b111, 1'b0, 32'd7, 32'd7, 32'h600, 32'h10, 1'b1, 0, -1);
    run_branch("reserved_010", 3'b010, 1'b0, 32'd1, 32'd1, 32'h700, 32'h10, 1'b1, 0, -1);
    run_branch("reserved_011", 3'b011, 1'b0, 32'd1, 32'd2, 32'h800, 32'h10, 1'b0, 0, -1);
  endtask

  task automatic test_misalign_wrap();
    run_branch("jump_misalign", 3'b000, 1'b1, 32'd1, 32'd2, 32'h200, 32'h6, 1'b0, 0, -1);
    run_branch("target_wrap", 3'b000, 1'b1, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h8, 1'b0, 0, -1);
    run_branch("seq_wrap", 3'b001, 1'b0, 32'd9, 32'd9, 32'hFFFF_FFFC, 32'h8, 1'b1, 0, -1);
  endtask

  task automatic test_ack_hold();
    run_branch("ack_hold10", 3'b000, 1'b0, 32'd1, 32'd2, 32'h900, 32'h44, 1'b1, 10, -1);
  endtask

  task automatic test_reset_mid_redirect();
    run_branch("rst_mid_redirect", 3'b000, 1'b1, 32'd0, 32'd0, 32'hA00, 32'h100, 1'b0, 10, 5);
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    for (int n = 0; n < 30; n++) begin
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      imm = ($urandom_range(0, 5) == 0) ? 32'($urandom) : (32'($urandom) & 32'hFFFF_FFFC);
      run_branch("random", 3'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0), a, b,
                 32'($urandom) & 32'hFFFF_FFFC, imm, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), -1);
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 20; n++) begin
      run_branch("saturate", 3'b000, 1'b1, 32'd0, 32'd1, 32'h1000 + 32'(n * 16), 32'h10, 1'b0, 0, -1);
    end
    n_tests++;
    if (mispred_cnt !== 4'hF || taken_cnt !== 4'hF) begin
      n_fail++;
      $display("FAIL saturation: mispred=%h taken=%h expected f f", mispred_cnt, taken_cnt);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_beq_redirect();
    test_signed_unsigned();
    test_ge_reserved();
    test_misalign_wrap();
    test_ack_hold();
    test_reset_mid_redirect();
    test_back_to_back();
    test_saturation();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
